// File: rtl/mpuc_w8_rot_if.sv
// Sample/result bundle for the W8^K rotator: strobed complex input with its
// rotation index, rotated complex output with valid pulse and sticky overflow.
interface mpuc_w8_rot_if #(
  parameter int NB = 12
);
  logic                 EI;
  logic                 ED;
  logic [2:0]           K;
  logic signed [NB-1:0] DR;
  logic signed [NB-1:0] DI;
  logic signed [NB-1:0] DOR;
  logic signed [NB-1:0] DOI;
  logic                 RDY;
  logic                 OVF;

  modport master (output EI, ED, K, DR, DI, input DOR, DOI, RDY, OVF);
  modport slave  (input EI, ED, K, DR, DI, output DOR, DOI, RDY, OVF);
endinterface

// File: rtl/mpuc_w8_rot.sv
// Complex rotation by W8^K = exp(-j*pi*K/4) for the radix-8/16 FFT datapath.
// One constant multiplier (C ~ 0.7071) is shared by the real and imaginary
// paths, so a new sample is accepted at most every second enabled cycle.
// Result appears three enabled edges after the strobe.
module mpuc_w8_rot #(
  parameter int NB  = 12,
  parameter int CB  = 16,
  parameter int RND = 1,
  parameter int SAT = 1
) (
  input logic          CLK,
  input logic          RST_N,
  mpuc_w8_rot_if.slave bus
);

  localparam int PW    = NB + CB + 2;
  localparam int RW    = NB + 2;
  localparam int C_INT = $rtoi(0.70710678 * (2.0 ** CB) + 0.5);
  localparam logic signed [PW-1:0] COEF = PW'(C_INT);
  localparam logic signed [PW-1:0] HALF = (RND != 0) ? (PW'(1) << (CB - 1)) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (NB - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  // Round half up (or floor) and drop the coefficient fraction bits.
  function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] biased;
    biased = p + HALF;
    return RW'(biased >>> CB);
  endfunction

  // True when a value cannot be represented in NB bits.
  function automatic logic clip_event(input logic signed [RW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Reduce to NB bits by clipping or by keeping the low bits.
  function automatic logic signed [NB-1:0] fit(input logic signed [RW-1:0] v);
    if ((SAT != 0) && (v > MAXV)) return MAXV[NB-1:0];
    if ((SAT != 0) && (v < MINV)) return MINV[NB-1:0];
    return v[NB-1:0];
  endfunction

  logic signed [NB:0]   a_p0, b_p0;
  logic [2:0]           k_p0;
  logic                 vld_p0;
  logic signed [PW-1:0] pa_p1;
  logic [2:0]           k_p1;
  logic                 vld_p1;
  logic signed [RW-1:0] re_p2, im_p2;
  logic [2:0]           k_p2;
  logic                 vld_p2;

  logic                 accept;
  logic signed [NB:0]   x_ext, y_ext, mul_in;
  logic signed [PW-1:0] mul_ext, prod;
  logic signed [RW-1:0] rot_re, rot_im;

  // Strobe qualification, operand widening and the shared multiplier; the
  // multiplier sees A while the sample sits in t0 and B one enabled cycle later.
  always_comb begin
    accept  = bus.EI & bus.ED & ~vld_p0;
    x_ext   = {bus.DR[NB-1], bus.DR};
    y_ext   = {bus.DI[NB-1], bus.DI};
    mul_in  = vld_p1 ? b_p0 : a_p0;
    mul_ext = {{(PW-NB-1){mul_in[NB]}}, mul_in};
    prod    = k_p0[0] ? (mul_ext * COEF) : (mul_ext <<< CB);
  end

  // Quarter-turn rotation selected by K[2:1].
  always_comb begin
    rot_re = re_p2;
    rot_im = im_p2;
    case (k_p2[2:1])
      2'd1: begin rot_re = im_p2;  rot_im = -re_p2; end
      2'd2: begin rot_re = -re_p2; rot_im = -im_p2; end
      2'd3: begin rot_re = -im_p2; rot_im = re_p2;  end
      default: ;
    endcase
  end

  // ---- t0: capture sample, pre-add for odd K ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p0 <= 1'b0;
      k_p0   <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
    end else if (bus.EI) begin
      vld_p0 <= accept;
      if (accept) begin
        k_p0 <= bus.K;
        if (bus.K[0]) begin
          a_p0 <= x_ext + y_ext;
          b_p0 <= y_ext - x_ext;
        end else begin
          a_p0 <= x_ext;
          b_p0 <= y_ext;
        end
      end
    end
  end

  // ---- t1: product of A ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
      k_p1   <= '0;
      pa_p1  <= '0;
    end else if (bus.EI) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        k_p1  <= k_p0;
        pa_p1 <= prod;
      end
    end
  end

  // ---- t2: product of B, both paths rounded back to integer scale ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p2 <= 1'b0;
      k_p2   <= '0;
      re_p2  <= '0;
      im_p2  <= '0;
    end else if (bus.EI) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        k_p2  <= k_p1;
        re_p2 <= round_shift(pa_p1);
        im_p2 <= round_shift(prod);
      end
    end
  end

  // ---- t3: rotate, limit to NB bits, flag overflow ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.RDY <= 1'b0;
      bus.OVF <= 1'b0;
      bus.DOR <= '0;
      bus.DOI <= '0;
    end else if (bus.EI) begin
      bus.RDY <= vld_p2;
      if (vld_p2) begin
        bus.DOR <= fit(rot_re);
        bus.DOI <= fit(rot_im);
        if (clip_event(rot_re) || clip_event(rot_im)) bus.OVF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpuc_w8_rot.sv
// Bench for mpuc_w8_rot: two instances (round+clip, floor+wrap) share one
// stimulus stream; expected results come from a complex-arithmetic model and
// are matched by a scoreboard monitor on RDY.
module tb_mpuc_w8_rot;
  localparam int NB = 12;
  localparam longint C = 46341;

  typedef struct {
    int     re;
    int     im;
    bit     ovf;
    longint at_edge;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mpuc_w8_rot_if #(.NB(NB)) bus_a ();
  mpuc_w8_rot_if #(.NB(NB)) bus_b ();

  mpuc_w8_rot #(.NB(NB), .CB(16), .RND(1), .SAT(1)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
  mpuc_w8_rot #(.NB(NB), .CB(16), .RND(0), .SAT(0)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

  exp_t   q_a[$];
  exp_t   q_b[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint en_cnt = 0;
  longint last_acc = -10;
  bit     ei_q = 1'b0;
  bit     sticky_a, sticky_b;
  int     hold_re_a, hold_im_a, hold_re_b, hold_im_b;

  function automatic void check(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint floor_div(longint v, longint d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic longint limit(longint v, bit sat);
    if (sat) return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    return (((v + 2048) % 4096) + 4096) % 4096 - 2048;
  endfunction

  // (x + jy) * W8^K: odd K scales by C/2^16*(1-j), then (-j)^(K/2).
  function automatic void model(input int x, input int y, input int k, input bit rnd,
                                input bit sat, output int o_re, output int o_im,
                                output bit ovf);
    longint re, im, t, half;
    half = rnd ? 32768 : 0;
    if (k % 2 == 1) begin
      re = floor_div(longint'(x + y) * C + half, 65536);
      im = floor_div(longint'(y - x) * C + half, 65536);
    end else begin
      re = x;
      im = y;
    end
    for (int i = 0; i < k / 2; i++) begin
      t  = re;
      re = im;
      im = -t;
    end
    ovf  = (re > 2047) || (re < -2048) || (im > 2047) || (im < -2048);
    o_re = int'(limit(re, sat));
    o_im = int'(limit(im, sat));
  endfunction

  task automatic push_sample(int k, int dr, int di, longint at);
    int r, i;
    bit o;
    model(dr, di, k, 1'b1, 1'b1, r, i, o);
    sticky_a |= o;
    q_a.push_back('{re: r, im: i, ovf: sticky_a, at_edge: at});
    model(dr, di, k, 1'b0, 1'b0, r, i, o);
    sticky_b |= o;
    q_b.push_back('{re: r, im: i, ovf: sticky_b, at_edge: at});
  endtask

  // Apply one cycle of inputs to both instances; predict capture from the
  // one-sample-per-two-enabled-cycles rule.
  task automatic drive(bit ei, bit ed, int k, int dr, int di);
    longint n;
    bus_a.EI = ei; bus_a.ED = ed; bus_a.K = 3'(k); bus_a.DR = NB'(dr); bus_a.DI = NB'(di);
    bus_b.EI = ei; bus_b.ED = ed; bus_b.K = 3'(k); bus_b.DR = NB'(dr); bus_b.DI = NB'(di);
    if (ei && ed && RST_N) begin
      n = en_cnt + 1;
      if (last_acc != n - 1) begin
        push_sample(k, dr, di, n + 3);
        last_acc = n;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(int cycles);
    RST_N = 1'b0;
    q_a.delete();
    q_b.delete();
    sticky_a = 0; sticky_b = 0;
    hold_re_a = 0; hold_im_a = 0; hold_re_b = 0; hold_im_b = 0;
    last_acc = -10;
    #1;
    check("rst_dor_a", bus_a.DOR, 0);
    check("rst_doi_a", bus_a.DOI, 0);
    check("rst_rdy_a", bus_a.RDY, 0);
    check("rst_ovf_a", bus_a.OVF, 0);
    check("rst_dor_b", bus_b.DOR, 0);
    check("rst_doi_b", bus_b.DOI, 0);
    check("rst_rdy_b", bus_b.RDY, 0);
    check("rst_ovf_b", bus_b.OVF, 0);
    repeat (cycles) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Count enabled edges; latency is measured in these.
  always @(posedge CLK) begin
    ei_q <= bus_a.EI;
    if (RST_N && bus_a.EI) en_cnt <= en_cnt + 1;
  end

  // Scoreboard monitor: pop on each fresh RDY, check hold while disabled.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (RST_N) begin
      if (ei_q) begin
        if (bus_a.RDY) begin
          if (q_a.size() == 0) check("a_unexpected_rdy", 1, 0);
          else begin
            e = q_a.pop_front();
            check("a_dor", bus_a.DOR, e.re);
            check("a_doi", bus_a.DOI, e.im);
            check("a_ovf", bus_a.OVF, e.ovf);
            check("a_latency_edge", en_cnt, e.at_edge);
            hold_re_a = e.re; hold_im_a = e.im;
          end
        end
        if (bus_b.RDY) begin
          if (q_b.size() == 0) check("b_unexpected_rdy", 1, 0);
          else begin
            e = q_b.pop_front();
            check("b_dor", bus_b.DOR, e.re);
            check("b_doi", bus_b.DOI, e.im);
            check("b_ovf", bus_b.OVF, e.ovf);
            check("b_latency_edge", en_cnt, e.at_edge);
            hold_re_b = e.re; hold_im_b = e.im;
          end
        end
      end else begin
        check("a_hold_dor", bus_a.DOR, hold_re_a);
        check("a_hold_doi", bus_a.DOI, hold_im_a);
        check("b_hold_dor", bus_b.DOR, hold_re_b);
        check("b_hold_doi", bus_b.DOI, hold_im_b);
      end
      if (q_a.size() != 0 && q_a[0].at_edge < en_cnt) begin
        check("a_missing_rdy", 0, 1);
        void'(q_a.pop_front());
      end
      if (q_b.size() != 0 && q_b[0].at_edge < en_cnt) begin
        check("b_missing_rdy", 0, 1);
        void'(q_b.pop_front());
      end
    end
  end

  int dk[10]  = '{0, 2, 4, 6, 1, 3, 4, 0, 1, 0};
  int ddr[10] = '{100, 100, 100, 100, 1000, 1, -2048, 5, 2047, 5};
  int ddi[10] = '{-200, -200, -200, -200, 0, 0, 0, 7, 2047, 7};
  int rk[16], rdr[16], rdi[16];

  initial begin
    RST_N = 1'b0;
    bus_a.EI = 0; bus_a.ED = 0; bus_a.K = 0; bus_a.DR = 0; bus_a.DI = 0;
    bus_b.EI = 0; bus_b.ED = 0; bus_b.K = 0; bus_b.DR = 0; bus_b.DI = 0;
    @(posedge CLK);
    #1;
    do_reset(3);

    // Directed corner samples, including overflow and sticky OVF afterwards.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, dk[i], ddr[i], ddi[i]);
      idle(4);
    end

    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      rk[i]  = int'($urandom_range(0, 7));
      rdr[i] = int'($urandom_range(0, 4095)) - 2048;
      rdi[i] = int'($urandom_range(0, 4095)) - 2048;
    end
    // Full-rate stream, ED every second enabled cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, rk[i], rdr[i], rdi[i]);
      drive(1'b1, 1'b0, int'($urandom_range(0, 7)), 77, -77);
    end
    idle(5);
    // Same stream with EI toggling; strobes on disabled cycles must be ignored.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, int'($urandom_range(0, 7)), 55, 66);
      drive(1'b1, 1'b1, rk[i], rdr[i], rdi[i]);
      drive(1'b0, 1'($urandom_range(0, 1)), 3, -9, 9);
      drive(1'b1, 1'b0, 0, 0, 0);
    end
    idle(5);
    // Fully random enable/strobe pattern.
    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    idle(5);

    // Back-to-back strobes: only the first is taken.
    drive(1'b1, 1'b1, 1, 300, 400);
    drive(1'b1, 1'b1, 0, -5, -6);
    idle(5);

    // Reset one cycle after a strobe discards the in-flight sample.
    drive(1'b1, 1'b1, 0, 100, -200);
    idle(4);
    drive(1'b1, 1'b1, 2, 321, -123);
    idle(1);
    do_reset(2);
    idle(8);

    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
